// File: rtl/overlay_triple_buffer_ctrl.sv
// Triple-buffer role manager (WRITE / READY / DISPLAY) for the overlay frame store.
// Optional statistics counters are enabled by defining OVERLAY_TB_STATS_EN.
module overlay_triple_buffer_ctrl #(
    parameter int          NUM_BUF       = 3,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter logic [31:0] FRAME_BYTES   = 32'h0004_B000,
    parameter bit          VS_ACTIVE_LOW = 1'b1,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             vga_vsync,
    input  logic             wr_done,
    output logic [1:0]       wr_buf,
    output logic [1:0]       rd_buf,
    output logic [31:0]      rd_base,
    output logic             frame_vsync,
    output logic             pending
`ifdef OVERLAY_TB_STATS_EN
    ,
    output logic [CNT_W-1:0] shown_cnt,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    if (NUM_BUF != 3) begin : g_bad_num_buf
        $error("overlay_triple_buffer_ctrl: NUM_BUF must be 3");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("overlay_triple_buffer_ctrl: CNT_W must be at least 1");
    end

    localparam logic [31:0] RESET_BASE = BASE_ADDR + FRAME_BYTES * 32'd2;

    // Per-buffer base addresses are elaboration-time constants, so the
    // display address is a table lookup rather than a multiplier.
    logic [31:0] base_lut [NUM_BUF];
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_base_lut
        assign base_lut[gi] = BASE_ADDR + 32'(gi) * FRAME_BYTES;
    end

    // ------------------------------------------------------------------
    // Input synchronisers: [0],[1] resynchronise, [2] is the edge flop.
    // ------------------------------------------------------------------
    logic [2:0] vs_sync_reg;
    logic [2:0] done_sync_reg;
    logic [2:0] arm_reg;
    logic       vs_start;
    logic       done_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_sync_reg   <= 3'b000;
            done_sync_reg <= 3'b000;
            arm_reg       <= 3'b111;
        end else begin
            vs_sync_reg   <= {vs_sync_reg[1:0], vga_vsync};
            done_sync_reg <= {done_sync_reg[1:0], wr_done};
            arm_reg       <= {1'b0, arm_reg[2:1]};
        end
    end

    // arm_reg masks done_evt until the first real wr_done level has reached
    // the edge flop, so the level present at reset release is not an event.
    always_comb begin
        vs_start = VS_ACTIVE_LOW ? (vs_sync_reg[2] & ~vs_sync_reg[1])
                                 : (~vs_sync_reg[2] & vs_sync_reg[1]);
        done_evt = (done_sync_reg[2] ^ done_sync_reg[1]) & ~arm_reg[0];
    end

    // ------------------------------------------------------------------
    // Role indices and output registers
    // ------------------------------------------------------------------
    logic [1:0]  w_reg, w_next;
    logic [1:0]  r_reg, r_next;
    logic [1:0]  d_reg, d_next;
    logic        pending_reg, pending_next;
    logic        en_reg;
    logic        frame_vsync_reg, frame_vsync_next;
    logic [1:0]  wr_buf_reg, wr_buf_next;
    logic [1:0]  rd_buf_reg, rd_buf_next;
    logic [31:0] rd_base_reg, rd_base_next;
    logic        restart;
    logic        done_acc;
    logic        vs_acc;

    always_comb begin
        w_next           = w_reg;
        r_next           = r_reg;
        d_next           = d_reg;
        pending_next     = pending_reg;
        restart          = enable & ~en_reg;
        done_acc         = done_evt & enable & ~restart;
        vs_acc           = vs_start & enable & ~restart;
        frame_vsync_next = frame_vsync_reg ^ vs_start;

        if (!enable) begin
            pending_next = 1'b0;
        end else if (restart) begin
            w_next       = 2'd0;
            r_next       = 2'd1;
            d_next       = 2'd2;
            pending_next = 1'b0;
        end else if (done_acc && vs_acc) begin
            // Done then vsync in one step: a three-way rotation.
            d_next       = w_reg;
            w_next       = r_reg;
            r_next       = d_reg;
            pending_next = 1'b0;
        end else if (done_acc) begin
            w_next       = r_reg;
            r_next       = w_reg;
            pending_next = 1'b1;
        end else if (vs_acc && pending_reg) begin
            d_next       = r_reg;
            r_next       = d_reg;
            pending_next = 1'b0;
        end

        wr_buf_next = enable ? w_next : 2'd0;
        rd_buf_next = enable ? d_next : 2'd0;

        case (rd_buf_reg)
            2'd1:    rd_base_next = base_lut[1];
            2'd2:    rd_base_next = base_lut[2];
            default: rd_base_next = base_lut[0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_reg           <= 2'd0;
            r_reg           <= 2'd1;
            d_reg           <= 2'd2;
            pending_reg     <= 1'b0;
            en_reg          <= 1'b1;
            frame_vsync_reg <= 1'b0;
            wr_buf_reg      <= 2'd0;
            rd_buf_reg      <= 2'd2;
            rd_base_reg     <= RESET_BASE;
        end else begin
            w_reg           <= w_next;
            r_reg           <= r_next;
            d_reg           <= d_next;
            pending_reg     <= pending_next;
            en_reg          <= enable;
            frame_vsync_reg <= frame_vsync_next;
            wr_buf_reg      <= wr_buf_next;
            rd_buf_reg      <= rd_buf_next;
            rd_base_reg     <= rd_base_next;
        end
    end

    assign wr_buf      = wr_buf_reg;
    assign rd_buf      = rd_buf_reg;
    assign rd_base     = rd_base_reg;
    assign frame_vsync = frame_vsync_reg;
    assign pending     = pending_reg;

`ifdef OVERLAY_TB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] shown_cnt_reg, shown_cnt_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic             shown_inc;
    logic             drop_inc;

    always_comb begin
        shown_inc      = vs_acc & (pending_reg | done_acc);
        drop_inc       = done_acc & pending_reg & ~vs_acc;
        shown_cnt_next = shown_cnt_reg;
        drop_cnt_next  = drop_cnt_reg;
        if (!enable) begin
            shown_cnt_next = '0;
            drop_cnt_next  = '0;
        end else begin
            if (shown_inc && !(&shown_cnt_reg)) begin
                shown_cnt_next = shown_cnt_reg + 1'b1;
            end
            if (drop_inc && !(&drop_cnt_reg)) begin
                drop_cnt_next = drop_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shown_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            shown_cnt_reg <= shown_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    assign shown_cnt = shown_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_overlay_triple_buffer_ctrl.sv
// Directed, table-driven bench for overlay_triple_buffer_ctrl.
module tb_overlay_triple_buffer_ctrl;

    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam logic [31:0] FB    = 32'h0004_B000;
    localparam int          CNT_W = 16;

    localparam int OP_DONE = 0;
    localparam int OP_VS   = 1;
    localparam int OP_BOTH = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b1;
    logic             vga_vsync = 1'b1;
    logic             wr_done = 1'b0;
    logic [1:0]       wr_buf;
    logic [1:0]       rd_buf;
    logic [31:0]      rd_base;
    logic             frame_vsync;
    logic             pending;
`ifdef OVERLAY_TB_STATS_EN
    logic [CNT_W-1:0] shown_cnt;
    logic [CNT_W-1:0] drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic exp_fv;
    logic en_s = 1'b0;

    overlay_triple_buffer_ctrl #(
        .NUM_BUF       (3),
        .BASE_ADDR     (BASE),
        .FRAME_BYTES   (FB),
        .VS_ACTIVE_LOW (1'b1),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .vga_vsync   (vga_vsync),
        .wr_done     (wr_done),
        .wr_buf      (wr_buf),
        .rd_buf      (rd_buf),
        .rd_base     (rd_base),
        .frame_vsync (frame_vsync),
        .pending     (pending)
`ifdef OVERLAY_TB_STATS_EN
        ,
        .shown_cnt   (shown_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         op;
        logic [1:0] wr;
        logic [1:0] rd;
        logic       pend;
        logic       fv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] ewr, input logic [1:0] erd,
                             input logic epend, input logic efv);
        check({tag, ".wr_buf"},      32'(wr_buf),      32'(ewr));
        check({tag, ".rd_buf"},      32'(rd_buf),      32'(erd));
        check({tag, ".rd_base"},     rd_base,          BASE + 32'(erd) * FB);
        check({tag, ".pending"},     32'(pending),     32'(epend));
        check({tag, ".frame_vsync"}, 32'(frame_vsync), 32'(efv));
        $display("vec %-12s wr=%0d rd=%0d base=%h pend=%0b fv=%0b", tag, wr_buf, rd_buf,
                 rd_base, pending, frame_vsync);
    endtask

    // Permutation invariant: WRITE and DISPLAY differ whenever enabled.
    always @(posedge clk) en_s = enable & reset_n;
    always @(negedge clk) begin
        if (reset_n && en_s) check("perm_invariant", 32'(wr_buf != rd_buf), 32'd1);
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b1;
        wr_done   = 1'b0;
        vga_vsync = 1'b1;
        exp_fv    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic toggle_done();
        @(negedge clk);
        wr_done = ~wr_done;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse(input logic with_done);
        @(negedge clk);
        vga_vsync = 1'b0;
        if (with_done) wr_done = ~wr_done;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vga_vsync = 1'b1;
        exp_fv = ~exp_fv;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        tbl[0] = '{OP_DONE, 2'd1, 2'd2, 1'b1, 1'b0};
        tbl[1] = '{OP_VS,   2'd1, 2'd0, 1'b0, 1'b1};
        tbl[2] = '{OP_DONE, 2'd2, 2'd0, 1'b1, 1'b1};
        tbl[3] = '{OP_DONE, 2'd1, 2'd0, 1'b1, 1'b1};
        tbl[4] = '{OP_DONE, 2'd2, 2'd0, 1'b1, 1'b1};
        tbl[5] = '{OP_VS,   2'd2, 2'd1, 1'b0, 1'b0};
        tbl[6] = '{OP_VS,   2'd2, 2'd1, 1'b0, 1'b1};
        tbl[7] = '{OP_BOTH, 2'd0, 2'd2, 1'b0, 1'b0};
        tbl[8] = '{OP_DONE, 2'd1, 2'd2, 1'b1, 1'b0};
        tbl[9] = '{OP_BOTH, 2'd0, 2'd1, 1'b0, 1'b1};

        // Reset state
        do_reset();
        check_out("reset", 2'd0, 2'd2, 1'b0, 1'b0);

        // Latency: wr_buf follows done by 3 clk, rd_base follows the VS edge by 4 clk
        @(negedge clk);
        wr_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("done_lat.wr_early", 32'(wr_buf), 32'd0);
        @(posedge clk);
        #1 check("done_lat.wr", 32'(wr_buf), 32'd1);
        check("done_lat.pend", 32'(pending), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vga_vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("vs_lat.rd_early", 32'(rd_buf), 32'd2);
        @(posedge clk);
        #1 check("vs_lat.rd", 32'(rd_buf), 32'd0);
        check("vs_lat.base_old", rd_base, BASE + 32'd2 * FB);
        check("vs_lat.fv", 32'(frame_vsync), 32'd1);
        check("vs_lat.pend", 32'(pending), 32'd0);
        @(posedge clk);
        #1 check("vs_lat.base_new", rd_base, BASE);
        @(negedge clk);
        vga_vsync = 1'b1;
        repeat (4) @(posedge clk);

        // Three done toggles without vsync
        do_reset();
        toggle_done(); check_out("done3_a", 2'd1, 2'd2, 1'b1, 1'b0);
        toggle_done(); check_out("done3_b", 2'd0, 2'd2, 1'b1, 1'b0);
        toggle_done(); check_out("done3_c", 2'd1, 2'd2, 1'b1, 1'b0);
`ifdef OVERLAY_TB_STATS_EN
        check("done3.drop_cnt", 32'(drop_cnt), 32'd2);
        check("done3.shown_cnt", 32'(shown_cnt), 32'd0);
`endif

        // Ten vsyncs with nothing ready
        do_reset();
        for (int i = 0; i < 10; i++) begin
            vs_pulse(1'b0);
            check("vs10.fv", 32'(frame_vsync), 32'(exp_fv));
        end
        check_out("vs10_end", 2'd0, 2'd2, 1'b0, 1'b0);
`ifdef OVERLAY_TB_STATS_EN
        check("vs10.shown_cnt", 32'(shown_cnt), 32'd0);
`endif

        // Table-driven sequence
        do_reset();
        for (int i = 0; i < 10; i++) begin
            case (tbl[i].op)
                OP_DONE: toggle_done();
                OP_VS:   vs_pulse(1'b0);
                default: vs_pulse(1'b1);
            endcase
            check_out($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].pend, tbl[i].fv);
        end
`ifdef OVERLAY_TB_STATS_EN
        check("tbl.shown_cnt", 32'(shown_cnt), 32'd4);
        check("tbl.drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // Disable: outputs forced to buffer 0, events ignored, vsync status still toggles
        exp_fv = frame_vsync;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_out("dis_a", 2'd0, 2'd0, 1'b0, exp_fv);
        toggle_done();
        vs_pulse(1'b0);
        check_out("dis_b", 2'd0, 2'd0, 1'b0, exp_fv);
`ifdef OVERLAY_TB_STATS_EN
        check("dis.shown_cnt", 32'(shown_cnt), 32'd0);
`endif
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_out("reen", 2'd0, 2'd2, 1'b0, exp_fv);
        toggle_done();
        check_out("reen_done", 2'd1, 2'd2, 1'b1, exp_fv);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_out("async_rst", 2'd0, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
